// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: num_pulses pulses of high_len high / low_len low cycles.
// Define PULSE_GEN_EDGE_FLAG_EN to add registered rise_flag/fall_flag edge indicators.
module pulse_gen #(
   parameter int LEN_W = 16,
   parameter int NUM_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stop,
   input  logic [LEN_W-1:0] high_len,
   input  logic [LEN_W-1:0] low_len,
   input  logic [NUM_W-1:0] num_pulses,
   output logic             sig_out,
   output logic             busy,
   output logic             done,
`ifdef PULSE_GEN_EDGE_FLAG_EN
   output logic             rise_flag,
   output logic             fall_flag,
`endif
   output logic             aborted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [NUM_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] high_m1_q, high_m1_d;
   logic [LEN_W-1:0] low_m1_q, low_m1_d;
   logic             sig_q, sig_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   // Lengths are stored as (len-1) saturating at 0, so a length of 0 behaves as 1.
   logic [LEN_W-1:0] high_in_m1, low_in_m1;
   assign high_in_m1 = (high_len == '0) ? '0 : high_len - LEN_W'(1);
   assign low_in_m1  = (low_len  == '0) ? '0 : low_len  - LEN_W'(1);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      high_m1_d = high_m1_q;
      low_m1_d  = low_m1_q;
      sig_d     = sig_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               if (num_pulses != '0) begin
                  high_m1_d = high_in_m1;
                  low_m1_d  = low_in_m1;
                  rem_d     = num_pulses;
                  cnt_d     = high_in_m1;
                  sig_d     = 1'b1;
                  state_d   = HIGH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         HIGH: begin
            if (stop) begin
               sig_d     = 1'b0;
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - LEN_W'(1);
            end else begin
               sig_d   = 1'b0;
               cnt_d   = low_m1_q;
               state_d = LOW;
            end
         end

         LOW: begin
            if (stop) begin
               sig_d     = 1'b0;
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - LEN_W'(1);
            end else if (rem_q > NUM_W'(1)) begin
               rem_d   = rem_q - NUM_W'(1);
               sig_d   = 1'b1;
               cnt_d   = high_m1_q;
               state_d = HIGH;
            end else begin
               rem_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            sig_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         high_m1_q <= '0;
         low_m1_q  <= '0;
         sig_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         high_m1_q <= high_m1_d;
         low_m1_q  <= low_m1_d;
         sig_q     <= sig_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign sig_out = sig_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;

`ifdef PULSE_GEN_EDGE_FLAG_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Flags coincide with the first cycle of the new sig_out level.
   always_comb begin
      rise_d = sig_d & ~sig_q;
      fall_d = ~sig_d & sig_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_flag = rise_q;
   assign fall_flag = fall_q;
`endif

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: expected waveforms are built as per-cycle queues from
// the pulse-train rules (max(len,1) ones then zeros per pulse) and compared every cycle.
module tb_pulse_gen;

   localparam int LEN_W = 16;
   localparam int NUM_W = 8;

   logic             clk = 1'b0;
   logic             rstn;
   logic             start;
   logic             stop;
   logic [LEN_W-1:0] high_len;
   logic [LEN_W-1:0] low_len;
   logic [NUM_W-1:0] num_pulses;
   logic             sig_out;
   logic             busy;
   logic             done;
   logic             aborted;
`ifdef PULSE_GEN_EDGE_FLAG_EN
   logic             rise_flag;
   logic             fall_flag;
`endif

   int checks = 0;
   int errors = 0;

   pulse_gen #(.LEN_W(LEN_W), .NUM_W(NUM_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .stop       (stop),
      .high_len   (high_len),
      .low_len    (low_len),
      .num_pulses (num_pulses),
      .sig_out    (sig_out),
      .busy       (busy),
      .done       (done),
`ifdef PULSE_GEN_EDGE_FLAG_EN
      .rise_flag  (rise_flag),
      .fall_flag  (fall_flag),
`endif
      .aborted    (aborted)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // Runs one train and checks it cycle by cycle. stop_at = index of the output cycle during
   // which stop is driven (-1 for none). Called and returns just after a falling edge.
   task automatic run_train(input int h, input int l, input int n, input int stop_at,
                            input string name);
      bit   exp_q[$];
      int   hh, ll, rises, falls;
      bit   prev_exp, stopped;
      logic prev_obs;
      hh = (h == 0) ? 1 : h;
      ll = (l == 0) ? 1 : l;
      for (int p = 0; p < n; p++) begin
         for (int k = 0; k < hh; k++) exp_q.push_back(1'b1);
         for (int k = 0; k < ll; k++) exp_q.push_back(1'b0);
      end

      high_len   = h[LEN_W-1:0];
      low_len    = l[LEN_W-1:0];
      num_pulses = n[NUM_W-1:0];
      start      = 1'b1;
      stop       = 1'b0;
      @(negedge clk);
      start = 1'b0;

      if (n == 0) begin
         checks++;
         if ({sig_out, busy, done, aborted} !== 4'b0010) begin
            errors++;
            $display("FAIL %s zero_pulses: {sig,busy,done,aborted}=%b expected 0010", name,
                     {sig_out, busy, done, aborted});
         end
         return;
      end

      prev_exp = 1'b0;
      prev_obs = 1'b0;
      rises    = 0;
      falls    = 0;
      stopped  = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if ({sig_out, busy, done, aborted} !== {exp_q[i], 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL %s cycle %0d: {sig,busy,done,aborted}=%b expected %b", name, i,
                     {sig_out, busy, done, aborted}, {exp_q[i], 1'b1, 2'b00});
         end
`ifdef PULSE_GEN_EDGE_FLAG_EN
         checks++;
         if ({rise_flag, fall_flag} !== {exp_q[i] & ~prev_exp, ~exp_q[i] & prev_exp}) begin
            errors++;
            $display("FAIL %s flags cycle %0d: {rise,fall}=%b expected %b", name, i,
                     {rise_flag, fall_flag}, {exp_q[i] & ~prev_exp, ~exp_q[i] & prev_exp});
         end
`endif
         if (sig_out === 1'b1 && prev_obs === 1'b0) rises++;
         if (sig_out === 1'b0 && prev_obs === 1'b1) falls++;
         prev_obs = sig_out;
         prev_exp = exp_q[i];
         // Garbage on every input while busy must not disturb the running train.
         start      = 1'($urandom_range(0, 1));
         high_len   = LEN_W'($urandom);
         low_len    = LEN_W'($urandom);
         num_pulses = NUM_W'($urandom);
         if (i == stop_at) begin
            stop    = 1'b1;
            stopped = 1'b1;
         end
         @(negedge clk);
         if (stopped) break;
      end
      start = 1'b0;
      stop  = 1'b0;

      if (stopped) begin
         checks++;
         if ({sig_out, busy, done, aborted} !== 4'b0001) begin
            errors++;
            $display("FAIL %s abort: {sig,busy,done,aborted}=%b expected 0001", name,
                     {sig_out, busy, done, aborted});
         end
`ifdef PULSE_GEN_EDGE_FLAG_EN
         checks++;
         if ({rise_flag, fall_flag} !== {1'b0, prev_exp}) begin
            errors++;
            $display("FAIL %s abort flags: {rise,fall}=%b expected %b", name,
                     {rise_flag, fall_flag}, {1'b0, prev_exp});
         end
`endif
      end else begin
         checks++;
         if ({sig_out, busy, done, aborted} !== 4'b0010) begin
            errors++;
            $display("FAIL %s done: {sig,busy,done,aborted}=%b expected 0010", name,
                     {sig_out, busy, done, aborted});
         end
         checks++;
         if (rises != n || falls != n) begin
            errors++;
            $display("FAIL %s edge_count: rises=%0d falls=%0d expected %0d each", name,
                     rises, falls, n);
         end
`ifdef PULSE_GEN_EDGE_FLAG_EN
         checks++;
         if ({rise_flag, fall_flag} !== 2'b00) begin
            errors++;
            $display("FAIL %s done flags: {rise,fall}=%b expected 00", name,
                     {rise_flag, fall_flag});
         end
`endif
      end
   endtask

   // Checks that everything stays quiet for a number of idle cycles.
   task automatic expect_idle(input int cycles, input string name);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         checks++;
         if ({sig_out, busy, done, aborted} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle %0d: {sig,busy,done,aborted}=%b expected 0000", name, i,
                     {sig_out, busy, done, aborted});
         end
      end
   endtask

   task automatic test_reset();
      rstn       = 1'b0;
      start      = 1'b1;
      stop       = 1'b0;
      high_len   = 16'd3;
      low_len    = 16'd3;
      num_pulses = 8'd2;
      #12;
      checks++;
      if ({sig_out, busy, done, aborted} !== 4'b0000) begin
         errors++;
         $display("FAIL reset: {sig,busy,done,aborted}=%b expected 0000",
                  {sig_out, busy, done, aborted});
      end
      start = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      expect_idle(2, "post_reset");
   endtask

   task automatic test_single();
      run_train(3, 2, 1, -1, "single_3_2_1");
   endtask

   task automatic test_toggle();
      run_train(1, 1, 4, -1, "toggle_1_1_4");
   endtask

   task automatic test_zero_len();
      run_train(0, 0, 2, -1, "zero_len");
      run_train(5, 5, 0, -1, "zero_pulses");
      expect_idle(2, "zero_pulses_after");
   endtask

   task automatic test_stop();
      run_train(10, 2, 3, 4, "stop_high");
      expect_idle(1, "stop_high_after");
      run_train(2, 4, 2, 3, "stop_low");
      expect_idle(1, "stop_low_after");
   endtask

   task automatic test_start_stop_idle();
      high_len   = 16'd2;
      low_len    = 16'd2;
      num_pulses = 8'd2;
      start      = 1'b1;
      stop       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      checks++;
      if ({sig_out, busy, done, aborted} !== 4'b0000) begin
         errors++;
         $display("FAIL start_stop_idle: {sig,busy,done,aborted}=%b expected 0000",
                  {sig_out, busy, done, aborted});
      end
      expect_idle(1, "start_stop_idle_after");
   endtask

   task automatic test_edge_flags();
      run_train(2, 3, 2, -1, "edge_flags_2_3_2");
   endtask

   task automatic test_back_to_back();
      run_train(2, 1, 2, -1, "b2b_first");
      run_train(1, 3, 1, -1, "b2b_second");
      run_train(3, 1, 2, 2, "b2b_abort");
      run_train(1, 2, 1, -1, "b2b_after_abort");
   endtask

   task automatic test_reset_mid_train();
      high_len   = 16'd3;
      low_len    = 16'd4;
      num_pulses = 8'd2;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({sig_out, busy} !== 2'b01) begin
         errors++;
         $display("FAIL mid_train_pre: {sig,busy}=%b expected 01", {sig_out, busy});
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({sig_out, busy, done, aborted} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_train_reset: {sig,busy,done,aborted}=%b expected 0000",
                  {sig_out, busy, done, aborted});
      end
`ifdef PULSE_GEN_EDGE_FLAG_EN
      checks++;
      if ({rise_flag, fall_flag} !== 2'b00) begin
         errors++;
         $display("FAIL mid_train_reset flags: {rise,fall}=%b expected 00",
                  {rise_flag, fall_flag});
      end
`endif
      @(negedge clk);
      rstn = 1'b1;
      expect_idle(3, "mid_train_release");
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         int h, l, n, total, stop_at;
         h     = $urandom_range(0, 5);
         l     = $urandom_range(0, 5);
         n     = $urandom_range(0, 4);
         total = n * ((h == 0 ? 1 : h) + (l == 0 ? 1 : l));
         stop_at = -1;
         if (total > 0 && $urandom_range(0, 3) == 0) stop_at = $urandom_range(0, total - 1);
         run_train(h, l, n, stop_at, $sformatf("random_%0d", t));
         if ($urandom_range(0, 1) == 1) expect_idle(1, $sformatf("random_gap_%0d", t));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_toggle();
      test_zero_len();
      test_stop();
      test_start_stop_idle();
      test_edge_flags();
      test_back_to_back();
      test_reset_mid_train();
      test_random();
      expect_idle(2, "final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
